// File: rtl/processor_help.sv
// ============================================================================
// Module      : processor_help (package)
// Description : Core-wide widths and the ROB allocation record shared by
//               rename and commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package processor_help;

    localparam int SUPER_SCALAR_WIDTH           = 2;
    localparam int PHYSICAL_REGISTER_FILE_SIZE  = 64;
    localparam int ARCHITECTURAL_REGISTER_COUNT = 32;

    localparam int PHYS_REG_WIDTH  = $clog2(PHYSICAL_REGISTER_FILE_SIZE);
    localparam int ARCH_REG_WIDTH  = $clog2(ARCHITECTURAL_REGISTER_COUNT);
    localparam int ROB_DEPTH_DEFAULT = 32;
    localparam int ROB_INDEX_WIDTH = $clog2(ROB_DEPTH_DEFAULT);

    typedef struct packed {
        logic                      slot_valid;
        logic                      writes_register;
        logic [ARCH_REG_WIDTH-1:0] arch_dest;
        logic [PHYS_REG_WIDTH-1:0] phys_dest;
    } RobAllocEntry;

endpackage

`default_nettype wire

// File: rtl/commit_free_select.sv
// ============================================================================
// Module      : commit_free_select
// Description : Retire-prefix selection, intra-group RRAT chaining and
//               compaction of freed registers into the low output slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_free_select
    import processor_help::*;
(
    input  logic [SUPER_SCALAR_WIDTH-1:0]                     i_head_valid,
    input  logic [SUPER_SCALAR_WIDTH-1:0]                     i_head_done,
    input  logic [SUPER_SCALAR_WIDTH-1:0]                     i_head_writes,
    input  logic [SUPER_SCALAR_WIDTH-1:0][ARCH_REG_WIDTH-1:0] i_head_arch,
    input  logic [SUPER_SCALAR_WIDTH-1:0][PHYS_REG_WIDTH-1:0] i_head_phys,
    input  logic [SUPER_SCALAR_WIDTH-1:0][PHYS_REG_WIDTH-1:0] i_head_rrat,
    output logic [SUPER_SCALAR_WIDTH-1:0]                     o_retire_mask,
    output logic [$clog2(SUPER_SCALAR_WIDTH+1)-1:0]           o_retire_count,
    output logic [SUPER_SCALAR_WIDTH-1:0]                     o_freed_valid,
    output logic [SUPER_SCALAR_WIDTH-1:0][PHYS_REG_WIDTH-1:0] o_freed_register
);

    localparam int c_W     = SUPER_SCALAR_WIDTH;
    localparam int c_SEL_W = $clog2(SUPER_SCALAR_WIDTH+1);

    logic                      w_alive;
    logic [c_W-1:0]            w_mask;
    logic [c_SEL_W-1:0]        w_count;
    logic [c_SEL_W-1:0]        w_pos;
    logic [PHYS_REG_WIDTH-1:0] w_freed;
    logic [c_W-1:0]                     w_out_valid;
    logic [c_W-1:0][PHYS_REG_WIDTH-1:0] w_out_reg;

    always_comb begin
        w_alive     = 1'b1;
        w_mask      = '0;
        w_count     = '0;
        w_pos       = '0;
        w_freed     = '0;
        w_out_valid = '0;
        w_out_reg   = '0;
        for (int i = 0; i < c_W; i++) begin
            if (w_alive && i_head_valid[i] && i_head_done[i]) begin
                w_mask[i] = 1'b1;
                w_count   = w_count + c_SEL_W'(1);
                if (i_head_writes[i]) begin
                    // The nearest earlier retiring writer of the same arch reg
                    // holds the mapping this entry supersedes.
                    w_freed = i_head_rrat[i];
                    for (int j = 0; j < i; j++) begin
                        if (w_mask[j] && i_head_writes[j] && (i_head_arch[j] == i_head_arch[i])) begin
                            w_freed = i_head_phys[j];
                        end
                    end
                    for (int o = 0; o < c_W; o++) begin
                        if (w_pos == c_SEL_W'(o)) begin
                            w_out_valid[o] = 1'b1;
                            w_out_reg[o]   = w_freed;
                        end
                    end
                    w_pos = w_pos + c_SEL_W'(1);
                end
            end else begin
                w_alive = 1'b0;
            end
        end
    end

    assign o_retire_mask    = w_mask;
    assign o_retire_count   = w_count;
    assign o_freed_valid    = w_out_valid;
    assign o_freed_register = w_out_reg;

endmodule

`default_nettype wire

// File: rtl/commit_unit.sv
// ============================================================================
// Module      : commit_unit
// Description : In-order retirement with reorder buffer and retirement RAT;
//               returns superseded physical registers to the free list.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_unit
    import processor_help::*;
#(
    parameter int ROB_DEPTH = 32
) (
    input  logic                                                 clk_in,
    input  logic                                                 rst_in,
    input  logic                                                 alloc_valid_in,
    output logic                                                 alloc_ready_out,
    input  RobAllocEntry [SUPER_SCALAR_WIDTH-1:0]                alloc_payload_in,
    output logic [SUPER_SCALAR_WIDTH-1:0][$clog2(ROB_DEPTH)-1:0] alloc_index_out,
    input  logic [SUPER_SCALAR_WIDTH-1:0]                        complete_valid_in,
    input  logic [SUPER_SCALAR_WIDTH-1:0][$clog2(ROB_DEPTH)-1:0] complete_index_in,
    output logic [SUPER_SCALAR_WIDTH-1:0]                        retire_valid_out,
    output logic [SUPER_SCALAR_WIDTH-1:0][PHYS_REG_WIDTH-1:0]    retire_freed_register_out,
    output logic                                                 empty_out
);

    localparam int c_W      = SUPER_SCALAR_WIDTH;
    localparam int c_IDX_W  = $clog2(ROB_DEPTH);
    localparam int c_CNT_W  = $clog2(ROB_DEPTH+1);
    localparam int c_SEL_W  = $clog2(SUPER_SCALAR_WIDTH+1);
    localparam int c_PHYS_W = PHYS_REG_WIDTH;
    localparam int c_ARCH_W = ARCH_REG_WIDTH;

    logic [ROB_DEPTH-1:0]                                r_valid;
    logic [ROB_DEPTH-1:0]                                r_done;
    logic [ROB_DEPTH-1:0]                                r_writes;
    logic [ROB_DEPTH-1:0][c_ARCH_W-1:0]                  r_arch;
    logic [ROB_DEPTH-1:0][c_PHYS_W-1:0]                  r_phys;
    logic [ARCHITECTURAL_REGISTER_COUNT-1:0][c_PHYS_W-1:0] r_rrat;
    logic [c_IDX_W-1:0]                                  r_head;
    logic [c_IDX_W-1:0]                                  r_tail;
    logic [c_CNT_W-1:0]                                  r_count;
    logic [c_W-1:0]                                      r_retire_valid;
    logic [c_W-1:0][c_PHYS_W-1:0]                        r_freed;

    logic                          w_alloc_fire;
    logic [c_SEL_W-1:0]            w_alloc_n;
    logic [c_W-1:0][c_SEL_W-1:0]   w_slot_off;
    logic [c_W-1:0][c_IDX_W-1:0]   w_hidx;
    logic [c_W-1:0]                w_h_valid;
    logic [c_W-1:0]                w_h_done;
    logic [c_W-1:0]                w_h_writes;
    logic [c_W-1:0][c_ARCH_W-1:0]  w_h_arch;
    logic [c_W-1:0][c_PHYS_W-1:0]  w_h_phys;
    logic [c_W-1:0][c_PHYS_W-1:0]  w_h_rrat;
    logic [c_W-1:0]                w_ret_mask;
    logic [c_SEL_W-1:0]            w_ret_n;
    logic [c_W-1:0]                w_free_valid;
    logic [c_W-1:0][c_PHYS_W-1:0]  w_free_reg;

    // Space is judged on the cycle-start count, so slots retired this cycle
    // only become allocatable next cycle.
    assign alloc_ready_out = (c_CNT_W'(ROB_DEPTH) - r_count) >= c_CNT_W'(c_W);
    assign w_alloc_fire    = alloc_valid_in && alloc_ready_out;
    assign empty_out       = (r_count == '0);

    assign retire_valid_out          = r_retire_valid;
    assign retire_freed_register_out = r_freed;

    always_comb begin
        w_alloc_n  = '0;
        w_slot_off = '0;
        for (int i = 0; i < c_W; i++) begin
            alloc_index_out[i] = r_tail + c_IDX_W'(i);
            w_slot_off[i]      = w_alloc_n;
            if (alloc_payload_in[i].slot_valid) begin
                w_alloc_n = w_alloc_n + c_SEL_W'(1);
            end
        end
    end

    always_comb begin
        w_hidx     = '0;
        w_h_valid  = '0;
        w_h_done   = '0;
        w_h_writes = '0;
        w_h_arch   = '0;
        w_h_phys   = '0;
        w_h_rrat   = '0;
        for (int i = 0; i < c_W; i++) begin
            w_hidx[i]     = r_head + c_IDX_W'(i);
            w_h_valid[i]  = r_valid[w_hidx[i]];
            w_h_done[i]   = r_done[w_hidx[i]];
            w_h_writes[i] = r_writes[w_hidx[i]];
            w_h_arch[i]   = r_arch[w_hidx[i]];
            w_h_phys[i]   = r_phys[w_hidx[i]];
            w_h_rrat[i]   = r_rrat[r_arch[w_hidx[i]]];
        end
    end

    commit_free_select u_free_select (
        .i_head_valid     (w_h_valid),
        .i_head_done      (w_h_done),
        .i_head_writes    (w_h_writes),
        .i_head_arch      (w_h_arch),
        .i_head_phys      (w_h_phys),
        .i_head_rrat      (w_h_rrat),
        .o_retire_mask    (w_ret_mask),
        .o_retire_count   (w_ret_n),
        .o_freed_valid    (w_free_valid),
        .o_freed_register (w_free_reg)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid        <= '0;
            r_done         <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_retire_valid <= '0;
            r_freed        <= '0;
            for (int a = 0; a < ARCHITECTURAL_REGISTER_COUNT; a++) begin
                r_rrat[a] <= c_PHYS_W'(a);
            end
        end else begin
            for (int i = 0; i < c_W; i++) begin
                if (complete_valid_in[i] && r_valid[complete_index_in[i]]) begin
                    r_done[complete_index_in[i]] <= 1'b1;
                end
            end
            // Ascending slot order lets the last writer of an arch reg win.
            for (int i = 0; i < c_W; i++) begin
                if (w_ret_mask[i]) begin
                    r_valid[w_hidx[i]] <= 1'b0;
                    r_done[w_hidx[i]]  <= 1'b0;
                    if (w_h_writes[i]) begin
                        r_rrat[w_h_arch[i]] <= w_h_phys[i];
                    end
                end
            end
            if (w_alloc_fire) begin
                for (int i = 0; i < c_W; i++) begin
                    if (alloc_payload_in[i].slot_valid) begin
                        r_valid[r_tail + c_IDX_W'(w_slot_off[i])]  <= 1'b1;
                        r_done[r_tail + c_IDX_W'(w_slot_off[i])]   <= 1'b0;
                        r_writes[r_tail + c_IDX_W'(w_slot_off[i])] <= alloc_payload_in[i].writes_register;
                        r_arch[r_tail + c_IDX_W'(w_slot_off[i])]   <= alloc_payload_in[i].arch_dest;
                        r_phys[r_tail + c_IDX_W'(w_slot_off[i])]   <= alloc_payload_in[i].phys_dest;
                    end
                end
                r_tail <= r_tail + c_IDX_W'(w_alloc_n);
            end
            r_head         <= r_head + c_IDX_W'(w_ret_n);
            r_count        <= r_count + (w_alloc_fire ? c_CNT_W'(w_alloc_n) : c_CNT_W'(0))
                                      - c_CNT_W'(w_ret_n);
            r_retire_valid <= w_free_valid;
            r_freed        <= w_free_reg;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_commit_unit.sv
// ============================================================================
// Module      : tb_commit_unit
// Description : Directed bench for commit_unit with ROB_DEPTH=8, W=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_unit;
    import processor_help::*;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic                alloc_valid_in;
    logic                alloc_ready_out;
    RobAllocEntry [1:0]  alloc_payload_in;
    logic [1:0][2:0]     alloc_index_out;
    logic [1:0]          complete_valid_in;
    logic [1:0][2:0]     complete_index_in;
    logic [1:0]          retire_valid_out;
    logic [1:0][5:0]     retire_freed_register_out;
    logic                empty_out;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    commit_unit #(.ROB_DEPTH(8)) dut (
        .clk_in                    (clk_in),
        .rst_in                    (rst_in),
        .alloc_valid_in            (alloc_valid_in),
        .alloc_ready_out           (alloc_ready_out),
        .alloc_payload_in          (alloc_payload_in),
        .alloc_index_out           (alloc_index_out),
        .complete_valid_in         (complete_valid_in),
        .complete_index_in         (complete_index_in),
        .retire_valid_out          (retire_valid_out),
        .retire_freed_register_out (retire_freed_register_out),
        .empty_out                 (empty_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic alloc_group(input logic wa, input logic [4:0] aa, input logic [5:0] pa,
                               input logic wb, input logic [4:0] ab, input logic [5:0] pb);
        alloc_payload_in[0] = '{slot_valid: 1'b1, writes_register: wa, arch_dest: aa, phys_dest: pa};
        alloc_payload_in[1] = '{slot_valid: 1'b1, writes_register: wb, arch_dest: ab, phys_dest: pb};
        alloc_valid_in      = 1'b1;
        tick();
        alloc_valid_in      = 1'b0;
        alloc_payload_in    = '0;
    endtask

    task automatic complete(input logic [1:0] v, input logic [2:0] i0, input logic [2:0] i1);
        complete_valid_in    = v;
        complete_index_in[0] = i0;
        complete_index_in[1] = i1;
        tick();
        complete_valid_in    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in            = 1'b1;
        alloc_valid_in    = 1'b0;
        alloc_payload_in  = '0;
        complete_valid_in = '0;
        complete_index_in = '0;
        tick();
        tick();
        rst_in = 1'b0;
        check("reset_retire_valid", retire_valid_out, 32'h0);
        check("reset_empty", empty_out, 32'h1);
        check("reset_ready", alloc_ready_out, 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_no_strobe", retire_valid_out, 32'h0);
        end

        // Basic retire
        check("basic_idx0", alloc_index_out[0], 32'd0);
        check("basic_idx1", alloc_index_out[1], 32'd1);
        alloc_group(1'b1, 5'd5, 6'd32, 1'b1, 5'd6, 6'd33);
        check("basic_not_empty", empty_out, 32'h0);
        complete(2'b11, 3'd0, 3'd1);
        check("basic_no_early_strobe", retire_valid_out, 32'h0);
        tick();
        check("basic_valid", retire_valid_out, 32'h3);
        check("basic_freed0", retire_freed_register_out[0], 32'd5);
        check("basic_freed1", retire_freed_register_out[1], 32'd6);
        check("basic_empty_again", empty_out, 32'h1);
        tick();
        check("basic_one_cycle", retire_valid_out, 32'h0);

        // Same-arch chain
        check("chain_idx0", alloc_index_out[0], 32'd2);
        alloc_group(1'b1, 5'd5, 6'd34, 1'b1, 5'd5, 6'd35);
        complete(2'b11, 3'd2, 3'd3);
        tick();
        check("chain_valid", retire_valid_out, 32'h3);
        check("chain_freed0", retire_freed_register_out[0], 32'd32);
        check("chain_freed1", retire_freed_register_out[1], 32'd34);

        // Out-of-order completion
        alloc_group(1'b1, 5'd8, 6'd40, 1'b1, 5'd9, 6'd41);
        complete(2'b01, 3'd5, 3'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ooo_wait", retire_valid_out, 32'h0);
        end
        complete(2'b01, 3'd4, 3'd0);
        tick();
        check("ooo_valid", retire_valid_out, 32'h3);
        check("ooo_freed0", retire_freed_register_out[0], 32'd8);
        check("ooo_freed1", retire_freed_register_out[1], 32'd9);

        // Packing: store retires without a strobe
        alloc_group(1'b0, 5'd0, 6'd0, 1'b1, 5'd7, 6'd36);
        complete(2'b11, 3'd6, 3'd7);
        tick();
        check("pack_valid", retire_valid_out, 32'h1);
        check("pack_freed0", retire_freed_register_out[0], 32'd7);
        tick();
        check("pack_empty", empty_out, 32'h1);
        check("wrap_idx0", alloc_index_out[0], 32'd0);

        // Full, drain two, refill, reset
        alloc_group(1'b1, 5'd1, 6'd42, 1'b1, 5'd2, 6'd43);
        alloc_group(1'b1, 5'd3, 6'd44, 1'b1, 5'd4, 6'd45);
        alloc_group(1'b1, 5'd10, 6'd46, 1'b1, 5'd11, 6'd47);
        check("three_groups_ready", alloc_ready_out, 32'h1);
        alloc_group(1'b1, 5'd12, 6'd48, 1'b1, 5'd13, 6'd49);
        check("full_ready", alloc_ready_out, 32'h0);
        complete(2'b11, 3'd0, 3'd1);
        check("full_ready_before_retire", alloc_ready_out, 32'h0);
        tick();
        check("full_retire_valid", retire_valid_out, 32'h3);
        check("full_freed0", retire_freed_register_out[0], 32'd1);
        check("full_freed1", retire_freed_register_out[1], 32'd2);
        check("full_ready_after_retire", alloc_ready_out, 32'h1);
        alloc_group(1'b1, 5'd14, 6'd50, 1'b1, 5'd15, 6'd51);
        check("refull_ready", alloc_ready_out, 32'h0);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("flush_empty", empty_out, 32'h1);
        check("flush_ready", alloc_ready_out, 32'h1);
        check("flush_retire_valid", retire_valid_out, 32'h0);
        check("flush_idx0", alloc_index_out[0], 32'd0);
        check("flush_idx1", alloc_index_out[1], 32'd1);

        // RRAT returns to identity after reset
        alloc_group(1'b1, 5'd5, 6'd52, 1'b1, 5'd6, 6'd53);
        complete(2'b11, 3'd0, 3'd1);
        tick();
        check("post_reset_valid", retire_valid_out, 32'h3);
        check("post_reset_freed0", retire_freed_register_out[0], 32'd5);
        check("post_reset_freed1", retire_freed_register_out[1], 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
